// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared 8N1 frame constants, bit-timing helper and FSM states.
// Imported by the receiver core and its testbench.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte bundle from the receiver to its consumer.
// The receiver drives it through master; consumers observe through slave.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (output data, valid, frame_err, busy);
    modport slave  (input  data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// uart_rx_sync_2ff: two-flop synchroniser for asynchronous inputs.
// Resets to RST so an idle-high line does not look like an edge.
module uart_rx_sync_2ff #(
    parameter int             W   = 1,
    parameter logic [W-1:0]   RST = '1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= RST;
            q    <= RST;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, mid-bit sampling, one-cycle valid/frame_err strobes.
// Start bit is re-checked at half period so short glitches fall back to IDLE.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     rx,
    uart_rx_if.master bus
);

    localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t HALF_M1 = cnt_t'(HALF - 1);
    localparam cnt_t LAST    = cnt_t'(CPB - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic       rx_s;
    logic       rx_s_d;
    logic       fall;
    state_t     state;
    cnt_t       cnt;
    logic [2:0] bitn;
    logic [7:0] shift;
    logic [7:0] data_q;
    logic       valid_q;
    logic       ferr_q;
    logic       busy_q;

    uart_rx_sync_2ff #(
        .W   (1),
        .RST (1'b1)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx),
        .q    (rx_s)
    );

    assign fall = rx_s_d & ~rx_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s_d  <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bitn    <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rx_s_d  <= rx_s;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fall) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt  <= '0;
                        bitn <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        bitn  <= bitn + 1'b1;
                        if (bitn == BIT_LAST) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        // A low stop bit discards the byte; data keeps the last good one.
                        if (rx_s) begin
                            data_q  <= shift;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bit-banged 8N1 frames into uart_rx, scoreboard of expected strobes.
// Covers loopback text, latency, glitch, framing error, mid-frame reset, baud skew.
module tb_uart_rx;

    logic clk = 1'b0;
    logic rstn;
    logic rx;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_pulse_cyc = 0;

    typedef struct {
        bit         ferr;
        logic [7:0] d;
    } exp_t;

    exp_t       q[$];
    logic [7:0] last_good;

    uart_rx_if u ();

    uart_rx dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .bus  (u)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One 8N1 frame, LSB first; the model decides the outcome from the stop bit.
    task automatic send(input logic [7:0] b, input bit stop, input int per);
        exp_t e;
        if (stop) begin
            e.ferr    = 1'b0;
            e.d       = b;
            last_good = b;
        end else begin
            e.ferr = 1'b1;
            e.d    = last_good;
        end
        q.push_back(e);
        rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (per) @(negedge clk);
        end
        rx = stop;
        repeat (per) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        string      s;
        int         c0;
        int         per;
        int         gap;
        bit         stop;
        logic [7:0] b;

        rstn      = 1'b0;
        rx        = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_data", u.data, 8'h00);
        chk("rst_valid", u.valid, 1'b0);
        chk("rst_ferr", u.frame_err, 1'b0);
        chk("rst_busy", u.busy, 1'b0);
        rstn = 1'b1;
        idle(5);

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rstn && (u.valid || u.frame_err)) begin
                    last_pulse_cyc = cyc;
                    chk("exclusive", 32'(u.valid & u.frame_err), 0);
                    chk("busy_on_pulse", u.busy, 1'b0);
                    if (q.size() == 0) begin
                        chk("unexpected_pulse", {u.valid, u.frame_err}, 2'b00);
                    end else begin
                        e = q.pop_front();
                        chk("kind", u.frame_err, e.ferr);
                        chk("data", u.data, e.d);
                    end
                end
            end
        join_none

        s = "Value: 101\n";
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1, 104);
        idle(20);

        c0 = cyc;
        send(8'hA5, 1'b1, 104);
        chk("latency", last_pulse_cyc - c0, 991);
        idle(20);

        c0 = cyc;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy", u.busy, 1'b1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (36) @(negedge clk);
        chk("glitch_idle", u.busy, 1'b0);
        idle(100);

        send(8'h11, 1'b1, 104);
        send(8'h3C, 1'b0, 104);
        idle(150);
        chk("ferr_data_hold", u.data, 8'h11);

        b  = 8'h5A;
        rx = 1'b0;
        repeat (104) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (104) @(negedge clk);
        end
        rx = b[4];
        repeat (52) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_data", u.data, 8'h00);
        chk("mid_rst_valid", u.valid, 1'b0);
        chk("mid_rst_ferr", u.frame_err, 1'b0);
        chk("mid_rst_busy", u.busy, 1'b0);
        last_good = 8'h00;
        idle(5);
        rstn = 1'b1;
        idle(10);
        send(8'h7E, 1'b1, 104);
        idle(20);

        send(8'h00, 1'b1, 102);
        send(8'hFF, 1'b1, 106);
        idle(30);

        for (int i = 0; i < 12; i++) begin
            b    = 8'($urandom);
            per  = $urandom_range(102, 106);
            stop = ($urandom_range(0, 5) != 0);
            send(b, stop, per);
            gap = stop ? $urandom_range(0, 20) : per + $urandom_range(0, 20);
            idle(gap);
        end

        idle(300);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
